// File: rtl/sw_pkg.sv
// Shared types and defaults for the switch allocator: per-output FSM encoding,
// default geometry and a constant-width helper.
package sw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } alloc_state_t;

  localparam int DEF_PORTS        = 5;
  localparam int DEF_CHANNEL_BITS = 3;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/sw_alloc_rr_arbiter.sv
// Round-robin picker: first set request at or after ptr, wrapping to index 0.
module rr_arbiter #(
  parameter int PORTS        = 5,
  parameter int CHANNEL_BITS = 3
) (
  input  logic [PORTS-1:0]        req,
  input  logic [CHANNEL_BITS-1:0] ptr,
  output logic [PORTS-1:0]        gnt,
  output logic [CHANNEL_BITS-1:0] idx,
  output logic                    any
);

  // Two passes avoid a data-dependent index: upper segment first, then wrap.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < PORTS; i++) begin
      if (!any && req[i] && (CHANNEL_BITS'(i) >= ptr)) begin
        any    = 1'b1;
        gnt[i] = 1'b1;
        idx    = CHANNEL_BITS'(i);
      end
    end
    for (int i = 0; i < PORTS; i++) begin
      if (!any && req[i]) begin
        any    = 1'b1;
        gnt[i] = 1'b1;
        idx    = CHANNEL_BITS'(i);
      end
    end
  end

endmodule

// File: rtl/sw_alloc.sv
// Crossbar switch allocator: one round-robin FSM per output channel granting an
// input for a fixed packet time, with per-input re-arm so a held request wins once.
module sw_alloc
  import sw_pkg::*;
#(
  parameter int PORTS        = DEF_PORTS,
  parameter int CHANNEL_BITS = DEF_CHANNEL_BITS,
  parameter int XFER_CYCLES  = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [PORTS-1:0]              sw_req,
  input  logic [PORTS*CHANNEL_BITS-1:0] sw_chnl,
  output logic [PORTS-1:0]              sw_gnt,
  output logic [PORTS*CHANNEL_BITS-1:0] out_sel,
  output logic [PORTS-1:0]              out_busy,
  output logic                          bad_chnl,
  output logic [2*PORTS-1:0]            dbg_state
);

  // Handshake: sw_req is a level; a request is consumed when sw_gnt rises, and
  // the same input only competes again after sw_req has been seen low once.
  localparam int CNT_W = (clog2(XFER_CYCLES) < 1) ? 1 : clog2(XFER_CYCLES);
  localparam logic [CHANNEL_BITS:0]   PORTS_LIM = (CHANNEL_BITS+1)'(PORTS);
  localparam logic [CNT_W-1:0]        CNT_LOAD  = CNT_W'(XFER_CYCLES - 1);
  localparam logic [CHANNEL_BITS-1:0] LAST_PORT = CHANNEL_BITS'(PORTS - 1);

  logic [PORTS-1:0]       armed, elig, bad_req, holding, issued;
  logic [PORTS-1:0]       active, granting;
  logic [PORTS*PORTS-1:0] issue_flat;

  always_comb begin
    elig    = '0;
    bad_req = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (armed[i] && sw_req[i]) begin
        if ({1'b0, sw_chnl[i*CHANNEL_BITS +: CHANNEL_BITS]} < PORTS_LIM)
          elig[i] = !holding[i];
        else
          bad_req[i] = 1'b1;
      end
    end
  end

  // An input tied to an output through GRANT or RELEASE may not compete anywhere.
  always_comb begin
    holding = '0;
    sw_gnt  = '0;
    for (int o = 0; o < PORTS; o++) begin
      for (int i = 0; i < PORTS; i++) begin
        if (out_sel[o*CHANNEL_BITS +: CHANNEL_BITS] == CHANNEL_BITS'(i)) begin
          if (active[o])   holding[i] = 1'b1;
          if (granting[o]) sw_gnt[i]  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    issued = '0;
    for (int o = 0; o < PORTS; o++) issued = issued | issue_flat[o*PORTS +: PORTS];
  end

  // A rejected out-of-range request is consumed like a grant, so bad_chnl is a pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed    <= '1;
      bad_chnl <= 1'b0;
    end else begin
      bad_chnl <= |bad_req;
      for (int i = 0; i < PORTS; i++) begin
        if (issued[i] || bad_req[i]) armed[i] <= 1'b0;
        else if (!sw_req[i])         armed[i] <= 1'b1;
      end
    end
  end

  for (genvar o = 0; o < PORTS; o++) begin : g_out
    alloc_state_t            state_q, state_d;
    logic [CNT_W-1:0]        cnt_q;
    logic [CHANNEL_BITS-1:0] ptr_q, sel_q, win_idx;
    logic [PORTS-1:0]        arb_req, win_onehot;
    logic                    win_any, take, busy_o, act_o;

    always_comb begin
      arb_req = '0;
      for (int i = 0; i < PORTS; i++)
        arb_req[i] = elig[i] && (sw_chnl[i*CHANNEL_BITS +: CHANNEL_BITS] == CHANNEL_BITS'(o));
    end

    rr_arbiter #(.PORTS(PORTS), .CHANNEL_BITS(CHANNEL_BITS)) u_arb (
      .req (arb_req),
      .ptr (ptr_q),
      .gnt (win_onehot),
      .idx (win_idx),
      .any (win_any)
    );

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        ptr_q   <= '0;
        sel_q   <= '0;
      end else begin
        state_q <= state_d;
        if (take) begin
          cnt_q <= CNT_LOAD;
          sel_q <= win_idx;
          ptr_q <= (win_idx == LAST_PORT) ? '0 : win_idx + 1'b1;
        end else if (state_q == ST_GRANT && cnt_q != '0) begin
          cnt_q <= cnt_q - 1'b1;
        end
      end
    end

    // RELEASE is the channel's dead cycle; the next winner is chosen during it so
    // back-to-back grants land XFER_CYCLES+1 cycles apart.
    always_comb begin
      state_d = state_q;
      take    = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (win_any) begin
            take    = 1'b1;
            state_d = ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (cnt_q == '0) state_d = ST_RELEASE;
        end
        ST_RELEASE: begin
          if (win_any) begin
            take    = 1'b1;
            state_d = ST_GRANT;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    always_comb begin
      busy_o = (state_q == ST_GRANT);
      act_o  = (state_q != ST_IDLE);
    end

    assign granting[o]                              = busy_o;
    assign active[o]                                = act_o;
    assign out_busy[o]                              = busy_o;
    assign out_sel[o*CHANNEL_BITS +: CHANNEL_BITS]  = sel_q;
    assign dbg_state[o*2 +: 2]                      = state_q;
    assign issue_flat[o*PORTS +: PORTS]             = win_onehot & {PORTS{take}};
  end

endmodule

// File: tb/tb_sw_alloc.sv
// Directed bench for sw_alloc: single, contention, parallel, re-arm, bad channel
// and mid-grant reset, with hand-computed expectations.
module tb_sw_alloc;

  localparam int PORTS = 5;
  localparam int CB    = 3;
  localparam int XFER  = 8;

  logic                  clk;
  logic                  reset;
  logic [PORTS-1:0]      sw_req;
  logic [PORTS*CB-1:0]   sw_chnl;
  logic [PORTS-1:0]      sw_gnt;
  logic [PORTS*CB-1:0]   out_sel;
  logic [PORTS-1:0]      out_busy;
  logic                  bad_chnl;
  logic [2*PORTS-1:0]    dbg_state;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  int         exp_cyc_q[$];

  sw_alloc #(.PORTS(PORTS), .CHANNEL_BITS(CB), .XFER_CYCLES(XFER)) dut (
    .clk       (clk),
    .reset     (reset),
    .sw_req    (sw_req),
    .sw_chnl   (sw_chnl),
    .sw_gnt    (sw_gnt),
    .out_sel   (out_sel),
    .out_busy  (out_busy),
    .bad_chnl  (bad_chnl),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic r, input int ch);
    sw_req[p]            = r;
    sw_chnl[p*CB +: CB]  = CB'(ch);
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    sw_req  = '0;
    sw_chnl = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  // scoreboard check
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  logic [PORTS-1:0] prev, rise, fall, raise_mask;
  int starts;

  initial begin
    reset   = 1'b1;
    sw_req  = '0;
    sw_chnl = '0;
    #1;
    chk("rst_gnt",   sw_gnt,    0);
    chk("rst_busy",  out_busy,  0);
    chk("rst_sel",   out_sel,   0);
    chk("rst_bad",   bad_chnl,  0);
    chk("rst_state", dbg_state, 0);

    // single: port 0 -> channel 2
    do_reset();
    drive(0, 1'b1, 2);
    chk("single_c0_gnt", sw_gnt, 0);
    for (int c = 1; c <= 10; c++) begin
      step();
      chk("single_gnt",  sw_gnt,   (c <= 8) ? 5'b00001 : 5'b00000);
      chk("single_busy", out_busy, (c <= 8) ? 5'b00100 : 5'b00000);
    end
    chk("single_sel", out_sel[8:6], 0);
    drive(0, 1'b0, 2);

    // contention: ports 1,3,4 on channel 0, re-arming after each grant
    do_reset();
    exp_q      = '{8'd1, 8'd3, 8'd4, 8'd1};
    exp_cyc_q  = '{1, 10, 19, 28};
    drive(1, 1'b1, 0);
    drive(3, 1'b1, 0);
    drive(4, 1'b1, 0);
    prev       = '0;
    raise_mask = '0;
    for (int c = 1; c <= 36; c++) begin
      step();
      for (int p = 0; p < PORTS; p++) if (raise_mask[p]) drive(p, 1'b1, 0);
      raise_mask = '0;
      rise = sw_gnt & ~prev;
      fall = prev & ~sw_gnt;
      if (rise != '0) begin
        if (exp_q.size() == 0) begin
          chk("contention_extra", rise, 0);
        end else begin
          chk("contention_port",  rise, 32'd1 << exp_q.pop_front());
          chk("contention_cycle", c, exp_cyc_q.pop_front());
        end
      end
      for (int p = 0; p < PORTS; p++) begin
        if (fall[p]) begin
          drive(p, 1'b0, 0);
          raise_mask[p] = 1'b1;
        end
      end
      prev = sw_gnt;
    end
    chk("contention_drained", exp_q.size(), 0);
    sw_req = '0;

    // parallel: port 0 -> ch1, port 2 -> ch3
    do_reset();
    drive(0, 1'b1, 1);
    drive(2, 1'b1, 3);
    for (int c = 1; c <= 9; c++) begin
      step();
      if (c == 1 || c == 8) begin
        chk("par_gnt",  sw_gnt,   5'b00101);
        chk("par_busy", out_busy, 5'b01010);
      end
      if (c == 9) begin
        chk("par_gnt_end",  sw_gnt,   0);
        chk("par_busy_end", out_busy, 0);
      end
    end
    chk("par_sel1", out_sel[5:3],  0);
    chk("par_sel3", out_sel[11:9], 2);
    sw_req = '0;

    // re-arm: held request wins once; a one-cycle drop wins again
    do_reset();
    drive(0, 1'b1, 0);
    prev   = '0;
    starts = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (sw_gnt[0] && !prev[0]) starts++;
      prev = sw_gnt;
    end
    chk("rearm_once", starts, 1);
    drive(0, 1'b0, 0);
    step();
    chk("rearm_gap", sw_gnt[0], 0);
    drive(0, 1'b1, 0);
    step();
    chk("rearm_second", sw_gnt[0], 1);
    chk("rearm_sel",    out_sel[2:0], 0);
    sw_req = '0;

    // bad channel: port 4 -> channel 6
    do_reset();
    drive(4, 1'b1, 6);
    for (int c = 1; c <= 6; c++) begin
      step();
      chk("bad_pulse",  bad_chnl, (c == 1) ? 1 : 0);
      chk("bad_no_gnt", sw_gnt,   0);
    end
    sw_req = '0;

    // reset mid-grant, then pointer restarts at port 0
    do_reset();
    drive(3, 1'b1, 0);
    for (int c = 1; c <= 4; c++) step();
    chk("mid_pre_gnt", sw_gnt,       5'b01000);
    chk("mid_pre_sel", out_sel[2:0], 3);
    reset = 1'b1;
    #1;
    chk("mid_rst_gnt",   sw_gnt,    0);
    chk("mid_rst_busy",  out_busy,  0);
    chk("mid_rst_sel",   out_sel,   0);
    chk("mid_rst_state", dbg_state, 0);
    drive(3, 1'b0, 0);
    step();
    reset = 1'b0;
    drive(0, 1'b1, 0);
    drive(4, 1'b1, 0);
    chk("post_rst_idle", sw_gnt, 0);
    step();
    chk("post_rst_gnt",  sw_gnt,   5'b00001);
    chk("post_rst_busy", out_busy, 5'b00001);
    sw_req = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
